// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Load-use, multi-cycle mul/div and branch-flush sequencing for the
//            5-stage core; drives PC / IF-ID / ID-EX enables and bubbles.
// Option   : STALL_STATS_EN adds the STALL_CYCLES stall-cycle counter port.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_controller #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_ADDR1,
  input  logic [4:0]  ID_ADDR2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_DEST_ADDR,
  input  logic        EX_MEM_READ,
  input  logic        EX_MULDIV,
  input  logic        EX_DIV,
  input  logic        BRANCH_FLUSH,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        ID_EX_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic        EX_MEM_BUBBLE,
  output logic        MULDIV_START,
  output logic        MULDIV_BUSY
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] STALL_CYCLES
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] lat_n;
  logic       load_use;

  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush;
  logic id_ex_bubble, ex_mem_bubble, muldiv_start, muldiv_busy;

  always_comb begin
    lat_n    = EX_DIV ? DIV_N : MUL_N;
    load_use = EX_MEM_READ && (EX_DEST_ADDR != 5'd0) &&
               ((ID_USES_RS1 && (ID_ADDR1 == EX_DEST_ADDR)) ||
                (ID_USES_RS2 && (ID_ADDR2 == EX_DEST_ADDR)));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    muldiv_start  = 1'b0;
    muldiv_busy   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (BRANCH_FLUSH) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (EX_MULDIV) begin
          muldiv_start = 1'b1;
          // The start cycle is the first of N EX cycles, so BUSY runs N-1 more.
          if (lat_n != 6'd1) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = BUSY;
            cnt_d         = lat_n - 6'd2;
          end
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      BUSY: begin
        muldiv_busy = 1'b1;
        if (cnt_q != 6'd0) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          cnt_d         = cnt_q - 6'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational, so gate them with reset to force zero immediately.
  assign PC_STALL      = RESET & pc_stall;
  assign IF_ID_STALL   = RESET & if_id_stall;
  assign ID_EX_STALL   = RESET & id_ex_stall;
  assign IF_ID_FLUSH   = RESET & if_id_flush;
  assign ID_EX_BUBBLE  = RESET & id_ex_bubble;
  assign EX_MEM_BUBBLE = RESET & ex_mem_bubble;
  assign MULDIV_START  = RESET & muldiv_start;
  assign MULDIV_BUSY   = RESET & muldiv_busy;

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, PC_STALL};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Self-checking bench: occupancy-based reference model compared every
//            cycle, plus directed vectors with literal expected outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_controller;

  localparam int MUL_N = 2;
  localparam int DIV_N = 8;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_addr1, id_addr2, ex_dest;
  logic       uses1, uses2, mem_rd, muldiv, is_div, br_flush;
  logic       pc_stall, if_id_stall, id_ex_stall, if_id_flush;
  logic       id_ex_bubble, ex_mem_bubble, md_start, md_busy;
  logic [7:0] outs;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .ID_ADDR1     (id_addr1),
    .ID_ADDR2     (id_addr2),
    .ID_USES_RS1  (uses1),
    .ID_USES_RS2  (uses2),
    .EX_DEST_ADDR (ex_dest),
    .EX_MEM_READ  (mem_rd),
    .EX_MULDIV    (muldiv),
    .EX_DIV       (is_div),
    .BRANCH_FLUSH (br_flush),
    .PC_STALL     (pc_stall),
    .IF_ID_STALL  (if_id_stall),
    .ID_EX_STALL  (id_ex_stall),
    .IF_ID_FLUSH  (if_id_flush),
    .ID_EX_BUBBLE (id_ex_bubble),
    .EX_MEM_BUBBLE(ex_mem_bubble),
    .MULDIV_START (md_start),
    .MULDIV_BUSY  (md_busy)
`ifdef STALL_STATS_EN
    ,
    .STALL_CYCLES (stall_cycles)
`endif
  );

  // Bit order: pc, if_id_stall, id_ex_stall, flush, id_ex_bub, ex_mem_bub, start, busy
  assign outs = {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
                 id_ex_bubble, ex_mem_bubble, md_start, md_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many EX-occupancy cycles of a mul/div remain.
  int          rem;
  int unsigned stat_model;

  function automatic logic [7:0] model_out(input int r);
    int  n;
    logic lu;
    logic s;
    if (!rst_n) return 8'h00;
    if (r > 0) begin
      s = (r > 1);
      return {s, s, s, 1'b0, 1'b0, s, 1'b0, 1'b1};
    end
    if (br_flush) return 8'b0001_1000;
    if (muldiv) begin
      n = is_div ? DIV_N : MUL_N;
      s = (n > 1);
      return {s, s, s, 1'b0, 1'b0, s, 1'b1, 1'b0};
    end
    lu = mem_rd && (ex_dest != 5'd0) &&
         ((uses1 && id_addr1 == ex_dest) || (uses2 && id_addr2 == ex_dest));
    if (lu) return 8'b1100_1000;
    return 8'h00;
  endfunction

  function automatic int model_next(input int r);
    int n;
    if (r > 0) return r - 1;
    n = is_div ? DIV_N : MUL_N;
    if (!br_flush && muldiv && n > 1) return n - 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= 0;
      stat_model <= 0;
    end else begin
      if (model_out(rem)[7]) stat_model <= stat_model + 1;
      rem <= model_next(rem);
    end
  end

  always @(negedge clk) begin
    chk("model_outs", {24'd0, outs}, {24'd0, model_out(rem)});
`ifdef STALL_STATS_EN
    chk("model_stall_cycles", stall_cycles, stat_model);
`endif
  end

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                        input logic u2, input logic [4:0] exd, input logic mr,
                        input logic md, input logic dv, input logic bf);
    id_addr1 = a1; id_addr2 = a2; uses1 = u1; uses2 = u2; ex_dest = exd;
    mem_rd = mr; muldiv = md; is_div = dv; br_flush = bf;
  endtask

  // Apply a vector just after the rising edge; return mid-cycle for sampling.
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                       input logic u2, input logic [4:0] exd, input logic mr,
                       input logic md, input logic dv, input logic bf);
    @(posedge clk);
    #1;
    set_in(a1, a2, u1, u2, exd, mr, md, dv, bf);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int starts;
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_outs", {24'd0, outs}, 32'h0);
    rst_n = 1'b1;

    // Load-use through rs1, then rs2; x0 and unused operands must not stall.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_rs1", {24'd0, outs}, 32'b1100_1000);
    idle();
    chk("load_use_release", {24'd0, outs}, 32'h0);
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_x0", {24'd0, outs}, 32'h0);
    drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_rs2", {24'd0, outs}, 32'b1100_1000);
    drive(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_rs2_unused", {24'd0, outs}, 32'h0);
    drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_load_no_stall", {24'd0, outs}, 32'h0);

    // MUL: one stall cycle with start, then one busy cycle without stall.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mul_start", {24'd0, outs}, 32'b1110_0110);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mul_final", {24'd0, outs}, 32'b0000_0001);
    // Back-to-back MUL is evaluated immediately after BUSY.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mul_back_to_back", {24'd0, outs}, 32'b1110_0110);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mul2_final", {24'd0, outs}, 32'b0000_0001);
    idle();
    chk("mul_idle", {24'd0, outs}, 32'h0);

    // DIV: 7 stall cycles, release on the 8th; flush/load-use ignored in BUSY.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("div_start", {24'd0, outs}, 32'b1110_0110);
    stalls = int'(pc_stall);
    starts = int'(md_start);
    for (int i = 1; i < DIV_N; i++) begin
      drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, (i == 4), 1'b1, 1'b1, (i == 3));
      stalls += int'(pc_stall);
      starts += int'(md_start);
      chk("div_busy", {24'd0, outs}, (i < DIV_N - 1) ? 32'b1110_0101 : 32'b0000_0001);
    end
    chk("div_stall_count", stalls, 32'd7);
    chk("div_start_count", starts, 32'd1);
    idle();
    chk("div_idle", {24'd0, outs}, 32'h0);

    // Branch flush wins over load-use and over a new mul/div in IDLE.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_over_load_use", {24'd0, outs}, 32'b0001_1000);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_over_muldiv", {24'd0, outs}, 32'b0001_1000);
    idle();
    chk("flush_stays_idle", {24'd0, outs}, 32'h0);

    // Asynchronous reset in the middle of a DIV.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("div_busy_before_reset", {24'd0, outs}, 32'b1110_0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_div", {24'd0, outs}, 32'h0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
`ifdef STALL_STATS_EN
    chk("stats_after_reset", stall_cycles, 32'd0);
`endif
    // A load-use stall proves the FSM came back in IDLE.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_after_reset", {24'd0, outs}, 32'b1100_1000);
    idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("div_after_reset", {24'd0, outs}, 32'b1110_0110);
    for (int i = 1; i < DIV_N; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("div_after_reset_final", {24'd0, outs}, 32'b0000_0001);
    idle();
`ifdef STALL_STATS_EN
    chk("stall_cycles_total", stall_cycles, 32'd8);
`endif
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
